pi1: RTL and testbench
======================

PI1 -- requirements
Module: pi1

Interface
REQ-001 The block SHALL have no parameters; the word width is fixed at 32 bits and the block width at 96 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port iword, input, 96 bits: the input block, with word0 = iword[31:0], word1 = iword[63:32] and word2 = iword[95:64].
REQ-005 The block SHALL have port ivalid, input, 1 bit: qualifies iword for the current cycle.
REQ-006 The block SHALL have port oword, output, 96 bits: the registered result block, with the same word layout as iword.
REQ-007 The block SHALL have port ovalid, output, 1 bit: high for one cycle when oword carries a new result.

Function
REQ-008 The block SHALL implement the 3-Way pi_1 word rotation; it SHALL NOT perform any XOR, substitution or key mixing.
REQ-009 Next oword[31:0] SHALL equal iword[31:0] rotated right by 10 bits: (w0 >> 10) | (w0 << 22), truncated to 32 bits.
REQ-010 Next oword[63:32] SHALL equal iword[63:32] unchanged.
REQ-011 Next oword[95:64] SHALL equal iword[95:64] rotated left by 1 bit: (w2 << 1) | (w2 >> 31), truncated to 32 bits.
REQ-012 Rotations SHALL be circular with no bit loss: bits leaving one end of a word re-enter at the other end of the same word, and no bit SHALL cross a word boundary.
REQ-013 Latency SHALL be exactly 1 cycle: when ivalid is high at rising edge N, oword SHALL be updated at edge N and ovalid SHALL be high for the cycle that follows.
REQ-014 When ivalid is low at a rising edge, oword SHALL hold its previous value and ovalid SHALL be low for the following cycle.
REQ-015 Back-to-back valid inputs SHALL be accepted every cycle with no stall; there is no backpressure input.
REQ-016 The transform SHALL be a pure function of iword; identical inputs SHALL yield identical outputs regardless of history.
REQ-017 Input values SHALL be sampled only at the rising clock edge; changes on iword between edges SHALL have no effect on the outputs.

Reset
REQ-018 While rst_n is low, oword SHALL be 96'h0 and ovalid SHALL be 0, regardless of clk.
REQ-019 Assertion of rst_n mid-stream SHALL immediately clear oword and ovalid, and any input sampled in that cycle SHALL be discarded.
REQ-020 After rst_n deasserts, the first valid input SHALL produce its result with the normal 1-cycle latency.

Verification
REQ-021 The bench SHALL drive w0=0x00000400, w1=0x12345678, w2=0x80000000 with ivalid=1, and SHALL require oword words {0x00000001, 0x12345678, 0x00000001} and ovalid=1 one cycle later.
REQ-022 The bench SHALL drive w0=0x00000001, w1=0, w2=0x00000001, and SHALL require {0x00400000, 0x00000000, 0x00000002}.
REQ-023 The bench SHALL drive all-ones input, and SHALL require all-ones output; it SHALL drive all-zeros input, and SHALL require all-zeros output.
REQ-024 The bench SHALL drive 100 random back-to-back valid words, and SHALL require every output to match a reference model applying REQ-009 to REQ-011, with ovalid high for each of them.
REQ-025 The bench SHALL hold ivalid=0 for 3 cycles after a result, and SHALL require oword to be unchanged and ovalid=0 throughout.
REQ-026 The bench SHALL pull rst_n low asynchronously between edges with a result pending, and SHALL require oword=0 and ovalid=0 immediately; after release, it SHALL require the next valid input to complete in 1 cycle.

Source files
------------

// File: rtl/pi1.sv
// rtl/pi1.sv - 3-Way pi_1 word rotation, one registered stage.
// Word0 rotates right by 10, word1 passes through, word2 rotates left by 1.
module pi1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] iword,
  input  logic        ivalid,
  output logic [95:0] oword,
  output logic        ovalid
);

  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [95:0] rot;
  logic [95:0] oword_d;
  logic [95:0] oword_q;
  logic        ovalid_d;
  logic        ovalid_q;

  assign w0 = iword[31:0];
  assign w1 = iword[63:32];
  assign w2 = iword[95:64];

  // Each rotation wraps within its own 32-bit word; nothing crosses a word boundary.
  assign rot = {{w2[30:0], w2[31]}, w1, {w0[9:0], w0[31:10]}};

  always_comb begin
    oword_d  = oword_q;
    ovalid_d = 1'b0;
    if (ivalid) begin
      oword_d  = rot;
      ovalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oword_q  <= 96'h0;
      ovalid_q <= 1'b0;
    end else begin
      oword_q  <= oword_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign oword  = oword_q;
  assign ovalid = ovalid_q;

endmodule

// File: tb/tb_pi1.sv
// tb/tb_pi1.sv - self-checking bench for pi1 against an arithmetic rotation model.
module tb_pi1;

  logic        clk;
  logic        rst_n;
  logic [95:0] iword;
  logic        ivalid;
  logic [95:0] oword;
  logic        ovalid;

  int checks;
  int passed;

  pi1 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iword  (iword),
    .ivalid (ivalid),
    .oword  (oword),
    .ovalid (ovalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] model(input logic [95:0] w);
    logic [31:0] a, b, c, ra, rc;
    a  = w[31:0];
    b  = w[63:32];
    c  = w[95:64];
    ra = (a >> 10) | (a << 22);
    rc = (c << 1) | (c >> 31);
    return {rc, b, ra};
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_out(input string name, input logic [95:0] exp_w, input logic exp_v);
    checks++;
    if (oword !== exp_w || ovalid !== exp_v)
      $display("FAIL %s: got oword=%h ovalid=%b, expected oword=%h ovalid=%b",
               name, oword, ovalid, exp_w, exp_v);
    else
      passed++;
  endtask

  task automatic apply(input logic [95:0] w, input logic v);
    iword  = w;
    ivalid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    iword  = rand96();
    ivalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_state", 96'h0, 1'b0);
    #2 rst_n = 1'b1;
    ivalid = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 96'h0, 1'b0);
  endtask

  task automatic test_vectors();
    apply({32'h80000000, 32'h12345678, 32'h00000400}, 1'b1);
    check_out("vec_rot_basic", {32'h00000001, 32'h12345678, 32'h00000001}, 1'b1);
    apply({32'h00000001, 32'h00000000, 32'h00000001}, 1'b1);
    check_out("vec_single_bit", {32'h00000002, 32'h00000000, 32'h00400000}, 1'b1);
    apply({96{1'b1}}, 1'b1);
    check_out("vec_all_ones", {96{1'b1}}, 1'b1);
    apply(96'h0, 1'b1);
    check_out("vec_all_zeros", 96'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [95:0] w;
    for (int i = 0; i < 100; i++) begin
      w = rand96();
      apply(w, 1'b1);
      check_out($sformatf("b2b_%0d", i), model(w), 1'b1);
    end
  endtask

  task automatic test_hold();
    logic [95:0] w, exp_w;
    w = rand96();
    exp_w = model(w);
    apply(w, 1'b1);
    check_out("hold_result", exp_w, 1'b1);
    for (int i = 0; i < 3; i++) begin
      iword  = rand96();
      ivalid = 1'b0;
      #2 iword = rand96();
      @(posedge clk);
      #1;
      check_out($sformatf("hold_idle_%0d", i), exp_w, 1'b0);
    end
    // Glitch iword between edges; only the value present at the edge may matter.
    w = rand96();
    iword  = rand96();
    ivalid = 1'b1;
    #3 iword = w;
    @(posedge clk);
    #1;
    check_out("edge_sampling", model(w), 1'b1);
  endtask

  task automatic test_async_reset();
    logic [95:0] w;
    w = rand96();
    apply(w, 1'b1);
    check_out("pending_result", model(w), 1'b1);
    iword = rand96();
    #2 rst_n = 1'b0;
    #1;
    check_out("async_clear", 96'h0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_discards_input", 96'h0, 1'b0);
    #2 rst_n = 1'b1;
    w = rand96();
    apply(w, 1'b1);
    check_out("first_after_reset", model(w), 1'b1);
    apply(rand96(), 1'b0);
    check_out("idle_after_first", model(w), 1'b0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    iword  = 96'h0;
    ivalid = 1'b0;
    #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
